sonar_serial_rx: RTL and testbench

- Receives the serial frames emitted by the sonar transmitter and recovers angle and distance.
- Line format: 7 data bits, odd parity, 1 stop bit, LSB first, idle high (7O1).
- Each frame is 8 ASCII characters: a2 a1 a0 ',' d2 d1 d0 '#'.
- Sits at the host/second-board end of the link. Drives 7-segment displays through the existing hexa7seg/mux path and feeds any downstream logger.

---
 rtl/sonar_serial_pkg.sv | 46 ++++
 rtl/sonar_serial_rx_uart.sv | 153 +++++++++++++++
 rtl/sonar_serial_rx.sv | 167 ++++++++++++++++
 tb/tb_sonar_serial_rx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_serial_pkg.sv
// ----------------------------------------------------------------------------
// sonar_serial_pkg
// Shared definitions for the sonar serial receiver:
//   - ASCII constants of the frame "a2 a1 a0 ',' d2 d1 d0 '#'"
//   - parser state encodings (codes 0..8, also shown on db_estado)
//   - RX bit-level state enum
//   - char_aceito(): does a character fit the slot the parser is waiting for
// ----------------------------------------------------------------------------
package sonar_serial_pkg;

    localparam logic [6:0] ASC_ZERO    = 7'h30;
    localparam logic [6:0] ASC_NOVE    = 7'h39;
    localparam logic [6:0] ASC_VIRGULA = 7'h2C;
    localparam logic [6:0] ASC_TERM    = 7'h23;

    typedef enum logic [3:0] {
        ESPERA_A2      = 4'd0,
        ESPERA_A1      = 4'd1,
        ESPERA_A0      = 4'd2,
        ESPERA_VIRGULA = 4'd3,
        ESPERA_D2      = 4'd4,
        ESPERA_D1      = 4'd5,
        ESPERA_D0      = 4'd6,
        ESPERA_TERM    = 4'd7,
        DESCARTA       = 4'd8
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_START    = 3'd1,
        RX_DADOS    = 3'd2,
        RX_PARIDADE = 3'd3,
        RX_STOP     = 3'd4
    } rx_state_t;

    // Digit slots accept '0'..'9'; the two punctuation slots accept one char each.
    function automatic logic char_aceito(input parser_state_t st, input logic [6:0] c);
        case (st)
            ESPERA_VIRGULA: return c == ASC_VIRGULA;
            ESPERA_TERM:    return c == ASC_TERM;
            DESCARTA:       return 1'b0;
            default:        return (c >= ASC_ZERO) && (c <= ASC_NOVE);
        endcase
    endfunction

endpackage

// File: rtl/sonar_serial_rx_uart.sv
// ----------------------------------------------------------------------------
// uart_rx_7o1
// 7O1 serial receiver (7 data bits LSB first, odd parity, 1 stop, idle high).
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   entrada_serial   : asynchronous RX line (2-FF synchronized internally)
//   char_ok          : 1-cycle pulse, character received with a good stop bit
//   char_erro        : 1-cycle pulse, stop bit was low (framing error)
//   dado[6:0]        : received character, valid while char_ok/char_erro pulse
//   erro_par         : parity flag accompanying char_ok (1 = bad parity)
// ----------------------------------------------------------------------------
module uart_rx_7o1
    import sonar_serial_pkg::*;
#(
    parameter int CLKS_POR_BIT = 434,
    parameter int N_CTD        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic       char_ok,
    output logic       char_erro,
    output logic [6:0] dado,
    output logic       erro_par
);

    localparam logic [N_CTD-1:0] FIM_BIT  = N_CTD'(CLKS_POR_BIT - 1);
    localparam logic [N_CTD-1:0] MEIO_BIT = N_CTD'(CLKS_POR_BIT / 2 - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             armed_q, armed_d;
    rx_state_t        estado_q, estado_d;
    logic [N_CTD-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [6:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             char_ok_q, char_ok_d;
    logic             char_erro_q, char_erro_d;
    logic             erro_par_q, erro_par_d;

    // Bit-level receiver: synchronizer, start qualification, bit sampling
    // at mid-cell, parity and stop checks.  armed_q blocks start detection
    // until the line has been seen high (after reset or a framing error),
    // so a stuck-low line is never mistaken for a stream of start bits.
    always_comb begin
        sync1_d     = entrada_serial;
        sync2_d     = sync1_q;
        armed_d     = armed_q | sync2_q;
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        char_ok_d   = 1'b0;
        char_erro_d = 1'b0;
        erro_par_d  = erro_par_q;
        case (estado_q)
            RX_IDLE: begin
                if (armed_q && !sync2_q) begin
                    estado_d = RX_START;
                    cnt_d    = '0;
                end
            end
            RX_START: begin
                if (cnt_q == MEIO_BIT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    estado_d  = sync2_q ? RX_IDLE : RX_DADOS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DADOS: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[6:1]};
                    if (bit_idx_q == 3'd6) begin
                        estado_d = RX_PARIDADE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_PARIDADE: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d    = '0;
                    par_d    = sync2_q;
                    estado_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d    = '0;
                    estado_d = RX_IDLE;
                    if (sync2_q) begin
                        char_ok_d  = 1'b1;
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        erro_par_d = ~(^{shift_q, par_q});
                    end else begin
                        char_erro_d = 1'b1;
                        erro_par_d  = 1'b0;
                        armed_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: estado_d = RX_IDLE;
        endcase
    end

    // Register bank; the synchronizer clears low so that a high line must
    // actually propagate through it before start detection is armed.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            armed_q     <= 1'b0;
            estado_q    <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            char_ok_q   <= 1'b0;
            char_erro_q <= 1'b0;
            erro_par_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            armed_q     <= armed_d;
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            char_ok_q   <= char_ok_d;
            char_erro_q <= char_erro_d;
            erro_par_q  <= erro_par_d;
        end
    end

    assign char_ok   = char_ok_q;
    assign char_erro = char_erro_q;
    assign dado      = shift_q;
    assign erro_par  = erro_par_q;

endmodule

// File: rtl/sonar_serial_rx.sv
// ----------------------------------------------------------------------------
// sonar_serial_rx
// Receives "a2a1a0,d2d1d0#" frames over a 7O1 serial line and publishes the
// BCD angle and distance of the last complete, error-free frame.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   entrada_serial   : asynchronous RX line, idle high
//   angulo[11:0]     : BCD {centena, dezena, unidade} of last valid frame
//   distancia[11:0]  : BCD {centena, dezena, unidade} of last valid frame
//   medida_valida    : 1-cycle pulse on the edge angulo/distancia update
//   erro_paridade    : 1-cycle pulse per bad-parity character (not while discarding)
//   erro_formato     : 1-cycle pulse per discarded frame
//   db_estado[3:0]   : parser state code 0..8
//   db_dado[6:0]     : last received character, valid or not
// ----------------------------------------------------------------------------
module sonar_serial_rx
    import sonar_serial_pkg::*;
#(
    parameter int CLKS_POR_BIT = 434,
    parameter int N_CTD        = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        medida_valida,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado,
    output logic [6:0]  db_dado
);

    logic       char_ok;
    logic       char_erro;
    logic [6:0] dado;
    logic       erro_par;

    uart_rx_7o1 #(
        .CLKS_POR_BIT (CLKS_POR_BIT),
        .N_CTD        (N_CTD)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .char_ok        (char_ok),
        .char_erro      (char_erro),
        .dado           (dado),
        .erro_par       (erro_par)
    );

    parser_state_t estado_q, estado_d;
    logic [23:0]   sombra_q, sombra_d;
    logic [11:0]   angulo_q, angulo_d;
    logic [11:0]   distancia_q, distancia_d;
    logic          medida_valida_q, medida_valida_d;
    logic          erro_paridade_q, erro_paridade_d;
    logic          erro_formato_q, erro_formato_d;
    logic [6:0]    db_dado_q, db_dado_d;

    logic char_bom;
    logic char_ruim;
    logic aceito;
    logic term_ignorado;

    assign char_bom      = char_ok && !erro_par;
    assign char_ruim     = char_erro || (char_ok && erro_par);
    assign aceito        = char_aceito(estado_q, dado);
    // A stray '#' while waiting for a new frame is dropped silently (resync aid).
    assign term_ignorado = (estado_q == ESPERA_A2) && (dado == ASC_TERM);

    // Parser state register and data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q        <= ESPERA_A2;
            sombra_q        <= '0;
            angulo_q        <= '0;
            distancia_q     <= '0;
            medida_valida_q <= 1'b0;
            erro_paridade_q <= 1'b0;
            erro_formato_q  <= 1'b0;
            db_dado_q       <= '0;
        end else begin
            estado_q        <= estado_d;
            sombra_q        <= sombra_d;
            angulo_q        <= angulo_d;
            distancia_q     <= distancia_d;
            medida_valida_q <= medida_valida_d;
            erro_paridade_q <= erro_paridade_d;
            erro_formato_q  <= erro_formato_d;
            db_dado_q       <= db_dado_d;
        end
    end

    // Next-state logic: walk the 8 slots of the frame; any bad char drops
    // into DESCARTA, which only a clean '#' leaves.
    always_comb begin
        estado_d = estado_q;
        if (estado_q == DESCARTA) begin
            if (char_bom && dado == ASC_TERM) begin
                estado_d = ESPERA_A2;
            end
        end else if (char_ruim) begin
            estado_d = DESCARTA;
        end else if (char_bom) begin
            if (term_ignorado) begin
                estado_d = ESPERA_A2;
            end else if (!aceito) begin
                estado_d = DESCARTA;
            end else if (estado_q == ESPERA_TERM) begin
                estado_d = ESPERA_A2;
            end else begin
                estado_d = parser_state_t'(estado_q + 4'd1);
            end
        end
    end

    // Output logic: digits collect in a shadow register and are published
    // only when the terminator closes the frame, so partial frames never
    // reach angulo/distancia.  Error pulses are suppressed while discarding.
    always_comb begin
        sombra_d        = sombra_q;
        angulo_d        = angulo_q;
        distancia_d     = distancia_q;
        db_dado_d       = db_dado_q;
        medida_valida_d = 1'b0;
        erro_paridade_d = 1'b0;
        erro_formato_d  = 1'b0;
        if (char_ok || char_erro) begin
            db_dado_d = dado;
        end
        if (estado_q != DESCARTA) begin
            if (char_ruim) begin
                erro_formato_d  = 1'b1;
                erro_paridade_d = char_ok && erro_par;
            end else if (char_bom && !term_ignorado) begin
                if (!aceito) begin
                    erro_formato_d = 1'b1;
                end else begin
                    case (estado_q)
                        ESPERA_A2: sombra_d[23:20] = dado[3:0];
                        ESPERA_A1: sombra_d[19:16] = dado[3:0];
                        ESPERA_A0: sombra_d[15:12] = dado[3:0];
                        ESPERA_D2: sombra_d[11:8]  = dado[3:0];
                        ESPERA_D1: sombra_d[7:4]   = dado[3:0];
                        ESPERA_D0: sombra_d[3:0]   = dado[3:0];
                        ESPERA_TERM: begin
                            angulo_d        = sombra_q[23:12];
                            distancia_d     = sombra_q[11:0];
                            medida_valida_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign angulo        = angulo_q;
    assign distancia     = distancia_q;
    assign medida_valida = medida_valida_q;
    assign erro_paridade = erro_paridade_q;
    assign erro_formato  = erro_formato_q;
    assign db_estado     = estado_q;
    assign db_dado       = db_dado_q;

endmodule

// File: tb/tb_sonar_serial_rx.sv
// ----------------------------------------------------------------------------
// tb_sonar_serial_rx
// Drives 7O1 frames into sonar_serial_rx (short bit time) and compares the
// outputs against a frame-level reference model kept in the bench.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sonar_serial_rx;

    localparam int CLKS = 16;
    localparam int NCTD = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        medida_valida;
    logic        erro_paridade;
    logic        erro_formato;
    logic [3:0]  db_estado;
    logic [6:0]  db_dado;

    sonar_serial_rx #(
        .CLKS_POR_BIT (CLKS),
        .N_CTD        (NCTD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .angulo         (angulo),
        .distancia      (distancia),
        .medida_valida  (medida_valida),
        .erro_paridade  (erro_paridade),
        .erro_formato   (erro_formato),
        .db_estado      (db_estado),
        .db_dado        (db_dado)
    );

    // 50 MHz clock
    always #10 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Pulse monitor: counts high cycles of each pulse output, parity errors
    // seen without a format error, and output changes outside medida_valida.
    int          c_val = 0, c_fmt = 0, c_par = 0, c_par_sozinho = 0, c_salto = 0;
    logic [11:0] ang_ant = '0, dist_ant = '0;
    logic        reset_ant = 1'b1;
    always @(negedge clock) begin
        if (!reset && !reset_ant) begin
            if (medida_valida) c_val++;
            if (erro_formato) c_fmt++;
            if (erro_paridade) c_par++;
            if (erro_paridade && !erro_formato) c_par_sozinho++;
            if (!medida_valida && (angulo !== ang_ant || distancia !== dist_ant)) c_salto++;
        end
        ang_ant   = angulo;
        dist_ant  = distancia;
        reset_ant = reset;
    end

    // Reference model: frame template matching at character level.
    string       padrao = "ddd,ddd#";
    int          m_pos = 0;
    int          m_dig[8];
    logic [11:0] m_ang = '0, m_dist = '0;
    logic [6:0]  m_dado = '0;
    int          m_val = 0, m_fmt = 0, m_par = 0;

    task automatic model_reset();
        m_pos  = 0;
        m_ang  = '0;
        m_dist = '0;
        m_dado = '0;
    endtask

    task automatic model_char(input logic [6:0] c, input bit par_ok, input bit stop_ok);
        byte t;
        bit  cabe;
        int  a, d;
        m_dado = c;
        if (m_pos == 8) begin
            if (par_ok && stop_ok && c == 7'h23) m_pos = 0;
            return;
        end
        if (!stop_ok || !par_ok) begin
            m_fmt++;
            if (stop_ok) m_par++;
            m_pos = 8;
            return;
        end
        if (m_pos == 0 && c == 7'h23) return;
        t = padrao[m_pos];
        cabe = (t == "d") ? (c >= 7'h30 && c <= 7'h39) : (c == t[6:0]);
        if (!cabe) begin
            m_fmt++;
            m_pos = 8;
            return;
        end
        m_dig[m_pos] = int'(c) - 48;
        if (m_pos == 7) begin
            a = m_dig[0] * 100 + m_dig[1] * 10 + m_dig[2];
            d = m_dig[4] * 100 + m_dig[5] * 10 + m_dig[6];
            m_ang  = {4'(a / 100), 4'((a / 10) % 10), 4'(a % 10)};
            m_dist = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            m_val++;
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulsa_reset();
        reset = 1'b1;
        ciclos(1);
        reset = 1'b0;
        model_reset();
    endtask

    // One 7O1 character; a bad stop bit is followed by one idle bit time.
    task automatic send_char(input logic [6:0] c, input bit flip_par, input bit stop_bom);
        logic p;
        p = ~(^c) ^ flip_par;
        entrada_serial = 1'b0;
        ciclos(CLKS);
        for (int i = 0; i < 7; i++) begin
            entrada_serial = c[i];
            ciclos(CLKS);
        end
        entrada_serial = p;
        ciclos(CLKS);
        entrada_serial = stop_bom;
        ciclos(CLKS);
        entrada_serial = 1'b1;
        if (!stop_bom) ciclos(CLKS);
        model_char(c, !flip_par, stop_bom);
    endtask

    task automatic send_str(input string s, input int gap);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], 1'b0, 1'b1);
            if (gap > 0) ciclos(gap);
        end
    endtask

    task automatic test_reset();
        entrada_serial = 1'b1;
        reset = 1'b1;
        ciclos(3);
        reset = 1'b0;
        model_reset();
        ciclos(1);
        if (angulo !== 12'h000) begin $display("[TB] FAIL reset_angulo: got %h want %h", angulo, 12'h000); n_err++; end
        n_cmp++;
        if (distancia !== 12'h000) begin $display("[TB] FAIL reset_distancia: got %h want %h", distancia, 12'h000); n_err++; end
        n_cmp++;
        if (db_estado !== 4'd0 || db_dado !== 7'h00) begin $display("[TB] FAIL reset_debug: got estado %0d dado %h want 0 00", db_estado, db_dado); n_err++; end
        n_cmp++;
        if ({medida_valida, erro_paridade, erro_formato} !== 3'b000) begin $display("[TB] FAIL reset_pulses: got %b want 000", {medida_valida, erro_paridade, erro_formato}); n_err++; end
        n_cmp++;
        ciclos(4);
    endtask

    task automatic test_single_frame();
        int v0, f0, p0;
        v0 = c_val; f0 = c_fmt; p0 = c_par;
        send_str("090,125#", 2);
        ciclos(8);
        if (angulo !== 12'h090 || distancia !== 12'h125) begin $display("[TB] FAIL single_values: got %h/%h want 090/125", angulo, distancia); n_err++; end
        n_cmp++;
        if (c_val - v0 !== 1) begin $display("[TB] FAIL single_medida_cycles: got %0d want 1", c_val - v0); n_err++; end
        n_cmp++;
        if (c_fmt - f0 !== 0 || c_par - p0 !== 0) begin $display("[TB] FAIL single_errors: got fmt %0d par %0d want 0 0", c_fmt - f0, c_par - p0); n_err++; end
        n_cmp++;
        if (db_estado !== 4'd0 || db_dado !== 7'h23) begin $display("[TB] FAIL single_debug: got %0d %h want 0 23", db_estado, db_dado); n_err++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = c_val; f0 = c_fmt;
        send_str("020,005#180,300#", 0);
        ciclos(8);
        if (angulo !== 12'h180 || distancia !== 12'h300) begin $display("[TB] FAIL b2b_values: got %h/%h want 180/300", angulo, distancia); n_err++; end
        n_cmp++;
        if (c_val - v0 !== 2 || c_fmt - f0 !== 0) begin $display("[TB] FAIL b2b_pulses: got val %0d fmt %0d want 2 0", c_val - v0, c_fmt - f0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_bad_char();
        int f0, v0;
        f0 = c_fmt; v0 = c_val;
        send_str("045,0x7#", 0);
        ciclos(8);
        if (c_fmt - f0 !== 1 || c_val - v0 !== 0) begin $display("[TB] FAIL badchar_pulses: got fmt %0d val %0d want 1 0", c_fmt - f0, c_val - v0); n_err++; end
        n_cmp++;
        if (angulo !== 12'h180 || distancia !== 12'h300) begin $display("[TB] FAIL badchar_hold: got %h/%h want 180/300", angulo, distancia); n_err++; end
        n_cmp++;
        if (db_estado !== 4'd0) begin $display("[TB] FAIL badchar_resync: got %0d want 0", db_estado); n_err++; end
        n_cmp++;
        send_str("045,017#", 0);
        ciclos(8);
        if (angulo !== 12'h045 || distancia !== 12'h017) begin $display("[TB] FAIL badchar_next: got %h/%h want 045/017", angulo, distancia); n_err++; end
        n_cmp++;
    endtask

    task automatic test_parity();
        int f0, p0;
        f0 = c_fmt; p0 = c_par;
        send_str("777", 0);
        send_char(7'h2C, 1'b1, 1'b1);
        send_str("888#", 0);
        ciclos(8);
        if (c_par - p0 !== 1 || c_fmt - f0 !== 1) begin $display("[TB] FAIL parity_pulses: got par %0d fmt %0d want 1 1", c_par - p0, c_fmt - f0); n_err++; end
        n_cmp++;
        if (c_par_sozinho !== 0) begin $display("[TB] FAIL parity_together: got %0d lone parity pulses want 0", c_par_sozinho); n_err++; end
        n_cmp++;
        if (angulo !== 12'h045 || distancia !== 12'h017) begin $display("[TB] FAIL parity_drop: got %h/%h want 045/017", angulo, distancia); n_err++; end
        n_cmp++;
        send_str("111,222#", 0);
        ciclos(8);
        if (angulo !== 12'h111 || distancia !== 12'h222) begin $display("[TB] FAIL parity_next: got %h/%h want 111/222", angulo, distancia); n_err++; end
        n_cmp++;
    endtask

    task automatic test_glitch();
        int         v0, f0, p0;
        logic [6:0] dado0;
        v0 = c_val; f0 = c_fmt; p0 = c_par; dado0 = db_dado;
        entrada_serial = 1'b0;
        ciclos(4);
        entrada_serial = 1'b1;
        ciclos(12 * CLKS);
        if (c_val != v0 || c_fmt != f0 || c_par != p0) begin $display("[TB] FAIL glitch_pulses: got %0d/%0d/%0d extra pulses want 0", c_val - v0, c_fmt - f0, c_par - p0); n_err++; end
        n_cmp++;
        if (db_estado !== 4'd0 || db_dado !== dado0) begin $display("[TB] FAIL glitch_state: got %0d %h want 0 %h", db_estado, db_dado, dado0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        send_str("123,4", 0);
        ciclos(4);
        if (db_estado !== 4'd5) begin $display("[TB] FAIL midreset_before: got %0d want 5", db_estado); n_err++; end
        n_cmp++;
        pulsa_reset();
        if (angulo !== 12'h000 || distancia !== 12'h000 || db_estado !== 4'd0 || db_dado !== 7'h00) begin
            $display("[TB] FAIL midreset_clear: got %h %h %0d %h want 000 000 0 00", angulo, distancia, db_estado, db_dado); n_err++;
        end
        n_cmp++;
        // Line held low across reset must not start a character.
        v0 = c_val; f0 = c_fmt;
        entrada_serial = 1'b0;
        ciclos(3);
        pulsa_reset();
        ciclos(20);
        entrada_serial = 1'b1;
        ciclos(12 * CLKS);
        if (db_dado !== 7'h00 || c_val != v0 || c_fmt != f0 || db_estado !== 4'd0) begin
            $display("[TB] FAIL lowreset_nostart: got dado %h pulses %0d/%0d estado %0d want 00 0/0 0", db_dado, c_val - v0, c_fmt - f0, db_estado); n_err++;
        end
        n_cmp++;
        send_str("000,999#", 0);
        ciclos(8);
        if (angulo !== 12'h000 || distancia !== 12'h999) begin $display("[TB] FAIL midreset_next: got %h/%h want 000/999", angulo, distancia); n_err++; end
        n_cmp++;
    endtask

    task automatic test_random();
        byte b;
        bit  flip, stop;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 99) < 85) begin
                    b = padrao[k];
                    if (b == "d") b = 8'(48 + $urandom_range(0, 9));
                end else if ($urandom_range(0, 3) == 0) begin
                    b = 8'h23;
                end else begin
                    b = 8'($urandom_range(0, 127));
                end
                flip = ($urandom_range(0, 29) == 0);
                stop = ($urandom_range(0, 39) != 0);
                send_char(b[6:0], flip, stop);
                ciclos($urandom_range(0, 3));
            end
            ciclos(8);
            if (angulo !== m_ang || distancia !== m_dist) begin $display("[TB] FAIL rand_values f%0d: got %h/%h want %h/%h", f, angulo, distancia, m_ang, m_dist); n_err++; end
            n_cmp++;
            if (db_estado !== 4'(m_pos) || db_dado !== m_dado) begin $display("[TB] FAIL rand_debug f%0d: got %0d %h want %0d %h", f, db_estado, db_dado, m_pos, m_dado); n_err++; end
            n_cmp++;
            if (c_val !== m_val || c_fmt !== m_fmt || c_par !== m_par) begin
                $display("[TB] FAIL rand_pulses f%0d: got %0d/%0d/%0d want %0d/%0d/%0d", f, c_val, c_fmt, c_par, m_val, m_fmt, m_par); n_err++;
            end
            n_cmp++;
        end
        if (c_par_sozinho !== 0 || c_salto !== 0) begin $display("[TB] FAIL rand_integrity: got lone par %0d jumps %0d want 0 0", c_par_sozinho, c_salto); n_err++; end
        n_cmp++;
    endtask

    // Watchdog: the sequence is a fixed length, this only guards against a hang.
    initial begin
        #(200000 * 20);
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_char();
        test_parity();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
